clz_iter_unit: RTL

- Parametrised, multi-cycle count-leading-zeros/ones unit for the ALU's bit-count instructions (CLZ and CLO).
- Uses a binary search over the operand, one halving step per clock, so the critical path is short for any WIDTH.
- Sits beside the ALU. The control unit starts it with a start/busy/done handshake and stalls until done.
- Adds two capabilities over a single-cycle 32-bit count: a selectable leading-ones mode and an abort input.

---
 rtl/clz_iter_if.sv | 23 ++
 rtl/clz_iter_unit.sv | 93 +++++++++
 2 files changed

// File: rtl/clz_iter_if.sv
// Handshake bundle between the control unit (master) and the leading-zero/one counter (slave).
interface clz_iter_if #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 32
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] operand;
    logic             abort;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] result;

    modport master (
        output start, mode, operand, abort,
        input  busy, done, result
    );

    modport slave (
        input  start, mode, operand, abort,
        output busy, done, result
    );
endinterface

// File: rtl/clz_iter_unit.sv
// Multi-cycle CLZ/CLO unit: a binary search over the operand that takes one halving step per clock,
// so each clock only has to compare one slice and do one shift.
module clz_iter_unit #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    clz_iter_if.slave  bus
);
    localparam int L  = $clog2(WIDTH);
    localparam int KW = $clog2(L) + 1;
    localparam logic [L:0] WIDTH_V = (L+1)'(WIDTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]       state_q;
    logic [WIDTH-1:0] s_q;
    logic [L:0]       count_q;
    logic [KW-1:0]    k_q;
    logic             z_q;
    logic [OUT_W-1:0] result_q;

    logic [L:0]       step;
    logic             top_zero;
    logic [WIDTH-1:0] s_nxt;
    logic [L:0]       count_nxt;
    logic [WIDTH-1:0] scan_in;
    logic             accept;

    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    always_comb begin
        step      = (L+1)'(1) << k_q;
        top_zero  = ((s_q >> (WIDTH_V - step)) == '0);
        s_nxt     = s_q;
        count_nxt = count_q;
        if (top_zero) begin
            s_nxt     = s_q << step;
            count_nxt = count_q + step;
        end
    end

    // Leading ones are counted as leading zeros of the inverted operand.
    assign scan_in = bus.mode ? ~bus.operand : bus.operand;
    assign accept  = (state_q != ST_SEARCH) && bus.start;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            count_q  <= '0;
            k_q      <= '0;
            z_q      <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (bus.abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        s_q     <= s_nxt;
                        count_q <= count_nxt;
                        if (k_q == '0) begin
                            state_q  <= ST_DONE;
                            // An all-zero scan value would otherwise stop at WIDTH-1.
                            result_q <= z_q ? OUT_W'(WIDTH_V) : OUT_W'(count_nxt);
                        end else begin
                            k_q <= k_q - 1'b1;
                        end
                    end
                end
                default: begin
                    if (accept) begin
                        s_q     <= scan_in;
                        z_q     <= (scan_in == '0);
                        count_q <= '0;
                        k_q     <= KW'(L - 1);
                        state_q <= ST_SEARCH;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy   = (state_q == ST_SEARCH);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;
endmodule
